ray_wall_scan_ctrl: RTL
=======================

// Module: ray_wall_scan_ctrl
// PURPOSE
// - Sequences one shared combinational rayCast datapath over a wall list held in a sync-read wall RAM.
// - Per ray: fetches each wall, presents ray+wall to rayCast, keeps nearest valid hit.
// - Returns {hit, distance, uv, wall id} via valid/ready; sits between column renderer and rayCast.
// PARAMETERS
// - WALL_AW    8       wall RAM address width; max walls = 2**WALL_AW
// - NEAR_CLIP  16'h0040 Q8.8 min accepted distance (used only with RAY_SCAN_NEAR_CLIP_EN)
// PORTS
// - clk            in   1   system clock
// - reset          in   1   asynchronous, active-high reset
// - start          in   1   1-cycle pulse: latch ray, begin scan (ignored when busy=1)
// - ray_x1/y1/x2/y2 in  16  ray points, Q8.8 signed
// - wall_count     in   WALL_AW+1 number of walls to scan, sampled on start
// - busy           out  1   high from accepted start until result handshake
// - wall_rd_en     out  1   wall RAM read strobe
// - wall_addr      out  WALL_AW wall RAM address
// - wall_data      in   64  {x3,y3,x4,y4} Q8.8, valid 1 cycle after wall_rd_en
// - rc_x1..rc_y4   out  16x8 registered operands to rayCast
// - rc_hit         in   1   rayCast intersection
// - rc_dist        in   16  rayCast ray_distance (unsigned compare)
// - rc_uv          in   16  rayCast uv_x
// - res_valid      out  1   result available
// - res_ready      in   1   consumer accepts result
// - res_hit / res_dist[16] / res_uv[16] / res_wall[WALL_AW] out  nearest-hit result
// BEHAVIOUR
// - Reset: state IDLE; busy, wall_rd_en, res_valid, res_hit = 0; all rc_*, res_dist, res_uv, res_wall, wall_addr = 0.
// - FSM: IDLE -> FETCH -> LOAD -> EVAL -> (FETCH | DONE) -> IDLE.
//   IDLE: start=1 latches ray into rc_x1..rc_y2, wall_count, idx=0, best_dist=16'hFFFF, best_hit=0; go FETCH (or DONE if wall_count==0).
//   FETCH: wall_rd_en=1, wall_addr=idx.  LOAD: register wall_data into rc_x3..rc_y4.
//   EVAL: rayCast outputs settled; accept if rc_hit && rc_dist < best_dist (strict: ties keep lower idx);
//         accept -> best_dist/uv/wall updated, best_hit=1. idx==wall_count-1 -> DONE else idx++ -> FETCH.
//   DONE: res_valid=1, res_* stable; res_valid&&res_ready -> IDLE, busy=0 next cycle.
// - Latency: 3 cycles/wall; start to res_valid = 3*wall_count+1 cycles (wall_count=0: 1 cycle).
// - No hit: res_hit=0, res_dist=0, res_uv=0, res_wall=0 (matches rayCast zero-on-miss convention).
// - idx counter WALL_AW+1 bits; wall_count=2**WALL_AW scans every entry, no wrap.
// - start during busy (incl. DONE) ignored; start coincident with accepting handshake ignored.
// - Ray operands held constant for whole scan; rc_x3..rc_y4 hold last wall after DONE.
// - reset asserted mid-scan: immediate return to reset values, no partial result emitted.
// CONFIGURATION
// - RAY_SCAN_NEAR_CLIP_EN defined: EVAL also requires rc_dist >= NEAR_CLIP; closer hits discarded (player inside wall).
// - Undefined: any rc_hit accepted regardless of distance; NEAR_CLIP unused.
// STRUCTURE
// - Shared package ray_pkg: Q8.8 width constant (16), Q8.8 ONE = 16'h0100, FSM state encoding
//   (IDLE/FETCH/LOAD/EVAL/DONE), wall record field offsets in the 64-bit word, DIST_MAX = 16'hFFFF.
// - rayCast instantiated outside; this block only drives/consumes its ports so it can be shared/muxed.
// - One sub-module: ray_best_hit (registered compare-and-keep of dist/uv/wall/hit, clear on start).
// TESTING (bench stubs wall RAM and rayCast responses per wall index)
// - 3 walls, rc = {hit 0x0500 uv 10},{hit 0x0300 uv 20},{hit 0x0400 uv 30} -> res_hit=1 dist=0x0300 uv=20 wall=1, res_valid at cycle 10.
// - 2 walls both hit 0x0200 -> res_wall=0 (tie keeps lower index).
// - wall_count=0 -> res_valid 1 cycle after start, res_hit=0, dist=0, uv=0; no wall_rd_en pulses.
// - 4 walls all rc_hit=0 -> res_hit=0, dist=0; exactly 4 wall_rd_en pulses at addr 0..3.
// - res_ready held low 5 cycles in DONE, extra start pulses -> res_* stable, second ray not started; ready=1 -> IDLE.
// - reset mid-EVAL of wall 2 -> all outputs 0 next cycle; new start scans from addr 0. NEAR_CLIP_EN: hit 0x0020 ignored, hit 0x0100 wins.

Source files
------------

// File: rtl/ray_pkg.sv
// Shared Q8.8 constants, scan FSM encoding and wall-record layout for the ray wall scanner.
package ray_pkg;

    localparam int Q_W = 16;
    localparam logic [Q_W-1:0] Q_ONE    = 16'h0100;
    localparam logic [Q_W-1:0] DIST_MAX = 16'hFFFF;

    // Wall record is {x3, y3, x4, y4}, x3 in the top half-word.
    localparam int WALL_X3_LSB = 48;
    localparam int WALL_Y3_LSB = 32;
    localparam int WALL_X4_LSB = 16;
    localparam int WALL_Y4_LSB = 0;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        EVAL  = 3'd3,
        DONE  = 3'd4
    } scan_state_t;

    function automatic logic [Q_W-1:0] wall_field(input logic [63:0] word, input int lsb);
        return word[lsb +: Q_W];
    endfunction

endpackage

// File: rtl/ray_best_hit.sv
// Registered nearest-hit keeper: cleared on scan start, updated on each evaluated wall.
// Optional RAY_SCAN_NEAR_CLIP_EN discards hits closer than NEAR_CLIP.
module ray_best_hit
    import ray_pkg::*;
#(
    parameter int              WALL_AW   = 8,
    parameter logic [Q_W-1:0]  NEAR_CLIP = 16'h0040
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_clear,
    input  logic               i_eval,
    input  logic               i_hit,
    input  logic [Q_W-1:0]     i_dist,
    input  logic [Q_W-1:0]     i_uv,
    input  logic [WALL_AW-1:0] i_wall,
    output logic               o_hit,
    output logic [Q_W-1:0]     o_dist,
    output logic [Q_W-1:0]     o_uv,
    output logic [WALL_AW-1:0] o_wall
);

`ifdef RAY_SCAN_NEAR_CLIP_EN
    localparam logic CLIP_EN = 1'b1;
`else
    localparam logic CLIP_EN = 1'b0;
`endif

    logic               r_hit;
    logic [Q_W-1:0]     r_dist;
    logic [Q_W-1:0]     r_uv;
    logic [WALL_AW-1:0] r_wall;
    logic               w_clip_ok;
    logic               w_accept;

    // Strict less-than keeps the lower wall index on equal distances.
    assign w_clip_ok = !CLIP_EN || (i_dist >= NEAR_CLIP);
    assign w_accept  = i_eval && i_hit && w_clip_ok && (i_dist < r_dist);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hit  <= 1'b0;
            r_dist <= DIST_MAX;
            r_uv   <= '0;
            r_wall <= '0;
        end else if (i_clear) begin
            r_hit  <= 1'b0;
            r_dist <= DIST_MAX;
            r_uv   <= '0;
            r_wall <= '0;
        end else if (w_accept) begin
            r_hit  <= 1'b1;
            r_dist <= i_dist;
            r_uv   <= i_uv;
            r_wall <= i_wall;
        end
    end

    // A miss reports all-zero fields, matching rayCast's own miss convention.
    assign o_hit  = r_hit;
    assign o_dist = r_hit ? r_dist : '0;
    assign o_uv   = r_hit ? r_uv   : '0;
    assign o_wall = r_hit ? r_wall : '0;

endmodule

// File: rtl/ray_wall_scan_ctrl.sv
// Scans the wall RAM for one ray through a shared rayCast datapath, returning the nearest hit.
// Build option RAY_SCAN_NEAR_CLIP_EN enables the near-clip filter in ray_best_hit.
//
// state | meaning
// IDLE  | waiting for start; ray latched on accept
// FETCH | wall RAM read issued for wall idx
// LOAD  | wall word registered into rc_x3..rc_y4
// EVAL  | rayCast settled; nearest-hit compare
// DONE  | result held until res_ready
module ray_wall_scan_ctrl
    import ray_pkg::*;
#(
    parameter int              WALL_AW   = 8,
    parameter logic [Q_W-1:0]  NEAR_CLIP = 16'h0040
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [Q_W-1:0]     i_ray_x1,
    input  logic [Q_W-1:0]     i_ray_y1,
    input  logic [Q_W-1:0]     i_ray_x2,
    input  logic [Q_W-1:0]     i_ray_y2,
    input  logic [WALL_AW:0]   i_wall_count,
    output logic               o_busy,
    output logic               o_wall_rd_en,
    output logic [WALL_AW-1:0] o_wall_addr,
    input  logic [63:0]        i_wall_data,
    output logic [Q_W-1:0]     o_rc_x1,
    output logic [Q_W-1:0]     o_rc_y1,
    output logic [Q_W-1:0]     o_rc_x2,
    output logic [Q_W-1:0]     o_rc_y2,
    output logic [Q_W-1:0]     o_rc_x3,
    output logic [Q_W-1:0]     o_rc_y3,
    output logic [Q_W-1:0]     o_rc_x4,
    output logic [Q_W-1:0]     o_rc_y4,
    input  logic               i_rc_hit,
    input  logic [Q_W-1:0]     i_rc_dist,
    input  logic [Q_W-1:0]     i_rc_uv,
    output logic               o_res_valid,
    input  logic               i_res_ready,
    output logic               o_res_hit,
    output logic [Q_W-1:0]     o_res_dist,
    output logic [Q_W-1:0]     o_res_uv,
    output logic [WALL_AW-1:0] o_res_wall
);

    scan_state_t r_state;
    scan_state_t w_state_nxt;

    logic [WALL_AW:0] r_idx;
    logic [WALL_AW:0] r_count;
    logic [Q_W-1:0]   r_rc_x1, r_rc_y1, r_rc_x2, r_rc_y2;
    logic [Q_W-1:0]   r_rc_x3, r_rc_y3, r_rc_x4, r_rc_y4;

    logic w_start_acc;
    logic w_last;
    logic w_load;
    logic w_eval;

    assign w_start_acc = (r_state == IDLE) && i_start;
    assign w_last      = (r_idx == r_count - (WALL_AW+1)'(1));

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_start) w_state_nxt = (i_wall_count == '0) ? DONE : FETCH;
            FETCH:   w_state_nxt = LOAD;
            LOAD:    w_state_nxt = EVAL;
            EVAL:    w_state_nxt = w_last ? DONE : FETCH;
            DONE:    if (i_res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_busy       = 1'b0;
        o_wall_rd_en = 1'b0;
        o_res_valid  = 1'b0;
        w_load       = 1'b0;
        w_eval       = 1'b0;
        case (r_state)
            IDLE:    ;
            FETCH:   begin o_busy = 1'b1; o_wall_rd_en = 1'b1; end
            LOAD:    begin o_busy = 1'b1; w_load = 1'b1; end
            EVAL:    begin o_busy = 1'b1; w_eval = 1'b1; end
            DONE:    begin o_busy = 1'b1; o_res_valid = 1'b1; end
            default: ;
        endcase
    end

    // idx is one bit wider than the address so a full 2**WALL_AW scan never wraps.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx   <= '0;
            r_count <= '0;
            r_rc_x1 <= '0;
            r_rc_y1 <= '0;
            r_rc_x2 <= '0;
            r_rc_y2 <= '0;
            r_rc_x3 <= '0;
            r_rc_y3 <= '0;
            r_rc_x4 <= '0;
            r_rc_y4 <= '0;
        end else begin
            if (w_start_acc) begin
                r_idx   <= '0;
                r_count <= i_wall_count;
                r_rc_x1 <= i_ray_x1;
                r_rc_y1 <= i_ray_y1;
                r_rc_x2 <= i_ray_x2;
                r_rc_y2 <= i_ray_y2;
            end
            if (w_load) begin
                r_rc_x3 <= wall_field(i_wall_data, WALL_X3_LSB);
                r_rc_y3 <= wall_field(i_wall_data, WALL_Y3_LSB);
                r_rc_x4 <= wall_field(i_wall_data, WALL_X4_LSB);
                r_rc_y4 <= wall_field(i_wall_data, WALL_Y4_LSB);
            end
            if (w_eval && !w_last) begin
                r_idx <= r_idx + (WALL_AW+1)'(1);
            end
        end
    end

    assign o_wall_addr = r_idx[WALL_AW-1:0];
    assign o_rc_x1     = r_rc_x1;
    assign o_rc_y1     = r_rc_y1;
    assign o_rc_x2     = r_rc_x2;
    assign o_rc_y2     = r_rc_y2;
    assign o_rc_x3     = r_rc_x3;
    assign o_rc_y3     = r_rc_y3;
    assign o_rc_x4     = r_rc_x4;
    assign o_rc_y4     = r_rc_y4;

    ray_best_hit #(
        .WALL_AW   (WALL_AW),
        .NEAR_CLIP (NEAR_CLIP)
    ) u_best_hit (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_clear (w_start_acc),
        .i_eval  (w_eval),
        .i_hit   (i_rc_hit),
        .i_dist  (i_rc_dist),
        .i_uv    (i_rc_uv),
        .i_wall  (r_idx[WALL_AW-1:0]),
        .o_hit   (o_res_hit),
        .o_dist  (o_res_dist),
        .o_uv    (o_res_uv),
        .o_wall  (o_res_wall)
    );

endmodule
